// File: rtl/inst_queue_if.sv
// Fetch/backend/dispatch side-band bundle of the instruction queue.
// Pure wiring, no latency.
// full is the back-pressure signal to fetch; out_ready is the back-pressure from dispatch.
interface inst_queue_if;
    logic        push_valid;
    logic [31:0] push_inst;
    logic [31:0] push_pc;
    logic        full;
    logic [31:0] redirect_pc;
    logic        br_valid;
    logic [31:0] br_target;
    logic        out_valid;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        out_ready;

    // Producer/consumer side: fetch, backend and dispatch.
    modport master (
        output push_valid, push_inst, push_pc, br_valid, br_target, out_ready,
        input  full, redirect_pc, out_valid, out_inst, out_pc
    );

    // Queue side.
    modport slave (
        input  push_valid, push_inst, push_pc, br_valid, br_target, out_ready,
        output full, redirect_pc, out_valid, out_inst, out_pc
    );
endinterface

// File: rtl/inst_queue.sv
// Circular instruction queue between fetch and dispatch that drops stalled branch/JALR re-fetches.
// Latency: a push is visible at the head one cycle later; head outputs are combinational.
// Backpressure: full asserts at DEPTH-1 entries (one spare slot); pops follow out_valid && out_ready.
module inst_queue #(
    parameter int ADDR_W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         rdy_i,
    inst_queue_if.slave  q
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W + 1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] MAX_LVL  = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {RUN, WAIT_BR, ARM, WAIT_TK} state_t;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } entry_t;

    entry_t              mem_q [DEPTH];
    logic [ADDR_W-1:0]   head_q, head_d, tail_q, tail_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic [31:0]         redirect_q;
    state_t              state_q, state_d;

    logic is_ctl, wr_en, pop, redir_load, redir_clear;

    assign is_ctl = (q.push_inst[6:0] == 7'b1100011) || (q.push_inst[6:0] == 7'b1100111);

    assign q.full        = (count_q >= FULL_LVL);
    assign q.out_valid   = (count_q != '0);
    assign q.out_inst    = mem_q[head_q].inst;
    assign q.out_pc      = mem_q[head_q].pc;
    assign q.redirect_pc = redirect_q;

    assign pop = rdy_i && q.out_valid && q.out_ready;

    // Filter state register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= RUN;
        else     state_q <= state_d;
    end

    // Next filter state: a written ctl parks us until the backend resolves it and fetch catches up.
    always_comb begin
        state_d = state_q;
        if (rdy_i) begin
            case (state_q)
                RUN:     if (wr_en && is_ctl) state_d = WAIT_BR;
                WAIT_BR: if (q.br_valid)      state_d = ARM;
                ARM:                          state_d = WAIT_TK;
                WAIT_TK: if (q.push_valid)    state_d = RUN;
                default:                      state_d = RUN;
            endcase
        end
    end

    // Filter outputs: only RUN writes; redirect loads on resolve and clears on fetch's final copy.
    always_comb begin
        wr_en       = rdy_i && q.push_valid && (state_q == RUN) && (count_q != MAX_LVL);
        redir_load  = rdy_i && q.br_valid   && (state_q == WAIT_BR);
        redir_clear = rdy_i && q.push_valid && (state_q == WAIT_TK);
    end

    // Pointer and occupancy next-state; push+pop together leaves count unchanged.
    always_comb begin
        head_d  = pop   ? head_q + ADDR_W'(1) : head_q;
        tail_d  = wr_en ? tail_q + ADDR_W'(1) : tail_q;
        count_d = count_q;
        case ({wr_en, pop})
            2'b10:   count_d = count_q + (ADDR_W + 1)'(1);
            2'b01:   count_d = count_q - (ADDR_W + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer, occupancy and redirect registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            redirect_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (redir_load)       redirect_q <= q.br_target;
            else if (redir_clear) redirect_q <= '0;
        end
    end

    // Entry storage; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[tail_q] <= '{inst: q.push_inst, pc: q.push_pc};
    end
endmodule

// File: tb/tb_inst_queue.sv
module tb_inst_queue;
    localparam logic [31:0] ALU  = 32'h0000_0013;
    localparam logic [31:0] BEQ  = 32'h0000_0063;
    localparam logic [31:0] JALR = 32'h0000_0067;

    logic clk = 1'b0;
    logic rst;
    logic rdy;
    always #5 clk = ~clk;

    inst_queue_if bus();
    inst_queue #(.ADDR_W(4)) dut (.clk(clk), .rst(rst), .rdy_i(rdy), .q(bus));

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
    } ent_t;

    // Reference model: queue contents, filter phase, redirect value.
    ent_t        mq[$];
    ent_t        sb[$];
    int          phase;      // 0 run, 1 waiting resolve, 2 arm, 3 waiting final copy
    logic [31:0] m_redir;
    bit          mon_en = 0;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic bit is_ctl(input logic [31:0] inst);
        return (inst[6:0] == 7'h63) || (inst[6:0] == 7'h67);
    endfunction

    // Model update on each active edge, from the same stable inputs the DUT samples.
    bit   m_pop, m_wr;
    ent_t m_e;
    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            sb.delete();
            phase   = 0;
            m_redir = 32'h0;
        end else if (rdy) begin
            m_pop  = (mq.size() != 0) && bus.out_ready;
            m_wr   = 1'b0;
            m_e.inst = bus.push_inst;
            m_e.pc   = bus.push_pc;
            case (phase)
                0: if (bus.push_valid && mq.size() < 16) begin
                       m_wr = 1'b1;
                       if (is_ctl(bus.push_inst)) phase = 1;
                   end
                1: if (bus.br_valid) begin
                       m_redir = bus.br_target;
                       phase   = 2;
                   end
                2: phase = 3;
                default: if (bus.push_valid) begin
                       m_redir = 32'h0;
                       phase   = 0;
                   end
            endcase
            if (m_pop) void'(mq.pop_front());
            if (m_wr) begin
                mq.push_back(m_e);
                sb.push_back(m_e);
            end
        end
    end

    // Monitor: status every cycle, and pop data against the scoreboard.
    ent_t s_e;
    always @(negedge clk) begin
        if (mon_en) begin
            chk("out_valid", 32'(bus.out_valid), 32'(mq.size() != 0));
            chk("full", 32'(bus.full), 32'(mq.size() >= 15));
            chk("redirect_pc", bus.redirect_pc, m_redir);
            if (!rst && rdy && bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pop_unexpected: got pc %h expected no entry", bus.out_pc);
                end else begin
                    s_e = sb.pop_front();
                    chk("pop_inst", bus.out_inst, s_e.inst);
                    chk("pop_pc", bus.out_pc, s_e.pc);
                end
            end
        end
    end

    task automatic drive(input bit pv, input logic [31:0] inst, input logic [31:0] pc,
                         input bit ordy, input bit bv, input logic [31:0] bt);
        bus.push_valid = pv;
        bus.push_inst  = inst;
        bus.push_pc    = pc;
        bus.out_ready  = ordy;
        bus.br_valid   = bv;
        bus.br_target  = bt;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit ordy);
        drive(1'b0, ALU, 32'h0, ordy, 1'b0, 32'h0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(1'b0);
        rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] inst, bt;
        rst = 1'b1;
        rdy = 1'b1;
        idle(1'b0);
        rst    = 1'b0;
        mon_en = 1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
        chk("rst_full", 32'(bus.full), 32'h0);
        chk("rst_redirect", bus.redirect_pc, 32'h0);

        // 1: streaming ALU ops with dispatch always ready.
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, ALU, 32'(i * 4), 1'b1, 1'b0, 32'h0);
            chk("t1_full", 32'(bus.full), 32'h0);
        end
        idle(1'b1);
        idle(1'b1);
        chk("t1_empty", 32'(bus.out_valid), 32'h0);

        // 2: fill with dispatch stalled, overflow push, then drain.
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, ALU, 32'h200 + 32'(i * 4), 1'b0, 1'b0, 32'h0);
            if (i == 13) chk("t2_full_at14", 32'(bus.full), 32'h0);
            if (i == 14) chk("t2_full_at15", 32'(bus.full), 32'h1);
        end
        chk("t2_head", bus.out_pc, 32'h200);
        for (int i = 0; i < 16; i++) idle(1'b1);
        chk("t2_drained", 32'(bus.out_valid), 32'h0);
        chk("t2_sb_empty", 32'(sb.size()), 32'h0);

        // 3: BEQ with stalled duplicates.
        drive(1'b1, BEQ, 32'h10, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 5; i++) drive(1'b1, BEQ, 32'h10, 1'b0, 1'b0, 32'h0);
        chk("t3_redirect", bus.redirect_pc, 32'h0);
        chk("t3_head", bus.out_pc, 32'h10);

        // 4: resolve, ARM drop, final copy drop, target accepted.
        drive(1'b0, ALU, 32'h0, 1'b0, 1'b1, 32'h40);
        chk("t4_redirect", bus.redirect_pc, 32'h40);
        drive(1'b1, ALU, 32'h14, 1'b0, 1'b0, 32'h0);
        chk("t4_arm_hold", bus.redirect_pc, 32'h40);
        drive(1'b1, BEQ, 32'h10, 1'b0, 1'b0, 32'h0);
        chk("t4_redirect_clr", bus.redirect_pc, 32'h0);
        drive(1'b1, ALU, 32'h40, 1'b0, 1'b0, 32'h0);
        idle(1'b1);
        chk("t4_second", bus.out_pc, 32'h40);
        idle(1'b1);
        chk("t4_empty", 32'(bus.out_valid), 32'h0);

        // 5: JALR written at count 14 makes the queue full; redirect proceeds anyway.
        do_reset();
        for (int i = 0; i < 14; i++) drive(1'b1, ALU, 32'h300 + 32'(i * 4), 1'b0, 1'b0, 32'h0);
        drive(1'b1, JALR, 32'h8, 1'b0, 1'b0, 32'h0);
        chk("t5_full", 32'(bus.full), 32'h1);
        for (int i = 0; i < 3; i++) drive(1'b1, JALR, 32'h8, 1'b0, 1'b0, 32'h0);
        drive(1'b0, ALU, 32'h0, 1'b0, 1'b1, 32'h100);
        chk("t5_redirect", bus.redirect_pc, 32'h100);
        idle(1'b1);
        idle(1'b1);
        chk("t5_full_clr", 32'(bus.full), 32'h0);
        chk("t5_hold", bus.redirect_pc, 32'h100);
        drive(1'b1, JALR, 32'h8, 1'b0, 1'b0, 32'h0);
        chk("t5_clr", bus.redirect_pc, 32'h0);
        drive(1'b1, ALU, 32'h100, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 15; i++) idle(1'b1);
        chk("t5_drained", 32'(bus.out_valid), 32'h0);

        // 6: reset while waiting for the final copy with 5 entries queued.
        for (int i = 0; i < 4; i++) drive(1'b1, ALU, 32'h500 + 32'(i * 4), 1'b0, 1'b0, 32'h0);
        drive(1'b1, BEQ, 32'h510, 1'b0, 1'b0, 32'h0);
        drive(1'b0, ALU, 32'h0, 1'b0, 1'b1, 32'h80);
        idle(1'b0);
        chk("t6_pre_redirect", bus.redirect_pc, 32'h80);
        do_reset();
        chk("t6_out_valid", 32'(bus.out_valid), 32'h0);
        chk("t6_full", 32'(bus.full), 32'h0);
        chk("t6_redirect", bus.redirect_pc, 32'h0);
        drive(1'b1, ALU, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("t6_accept", bus.out_pc, 32'h0);
        drive(1'b1, ALU, 32'h4, 1'b0, 1'b0, 32'h0);
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, ALU, 32'h8, 1'b1, 1'b1, 32'h44);
            chk("t6_rdy_hold", bus.out_pc, 32'h0);
        end
        rdy = 1'b1;
        idle(1'b1);
        chk("t6_resume", bus.out_pc, 32'h4);
        idle(1'b1);
        chk("t6_empty", 32'(bus.out_valid), 32'h0);

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 399) == 0);
            rdy = ($urandom_range(0, 9) != 0);
            inst = $urandom & 32'hFFFF_FF80;
            if ($urandom_range(0, 6) == 0) inst = inst | (($urandom_range(0, 1) == 0) ? BEQ : JALR);
            else                           inst = inst | 32'h13;
            bt = ($urandom & 32'hFFFF_FFFC) | 32'h4;
            drive(($urandom_range(0, 9) < 7), inst, $urandom & 32'hFFFF_FFFC,
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 4) == 0), bt);
        end
        rst = 1'b0;
        rdy = 1'b1;
        for (int i = 0; i < 20; i++) idle(1'b1);
        chk("final_sb_empty", 32'(sb.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
